// File: rtl/alu_writeback.sv
// Write-back stage behind the registered ALU: pairs each result with its issue tag,
// derives N/Z/C/V and queues register-file writes under a credit-based issue gate.
module alu_writeback #(
  parameter int DATA_BITS     = 8,
  parameter int REG_ADDR_BITS = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [REG_ADDR_BITS-1:0] issue_dst,
  input  logic                     issue_sub,
  input  logic                     issue_a_msb,
  input  logic                     issue_b_msb,
  input  logic [DATA_BITS-1:0]     alu_result,
  input  logic                     alu_cout,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [REG_ADDR_BITS-1:0] wb_addr,
  output logic [DATA_BITS-1:0]     wb_data,
  output logic [3:0]               flags
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] addr;
    logic                     sub;
    logic                     a_msb;
    logic                     b_msb;
  } tag_t;

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0]     data;
    logic [3:0]               flags;
  } entry_t;

  tag_t             p_tag;
  logic             p_valid;
  entry_t           mem [FIFO_DEPTH];
  entry_t           head, new_entry, next_head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0] count, count_after_pop, count_next;
  logic             accept, push, pop, r_msb, ovf;

  // Credit counts the in-flight ALU op so a push can never find the queue full.
  assign issue_ready = rst_n & ((count + CNT_W'(p_valid)) < CNT_W'(FIFO_DEPTH));
  assign accept      = issue_valid & issue_ready;
  assign push        = p_valid;
  assign wb_valid    = (count != '0);
  assign pop         = wb_valid & wb_ready;
  assign wb_addr     = head.addr;
  assign wb_data     = head.data;

  always_comb begin
    r_msb = alu_result[DATA_BITS-1];
    if (p_tag.sub)
      ovf = (p_tag.a_msb != p_tag.b_msb) & (r_msb != p_tag.a_msb);
    else
      ovf = (p_tag.a_msb == p_tag.b_msb) & (r_msb != p_tag.a_msb);
    new_entry.addr  = p_tag.addr;
    new_entry.data  = alu_result;
    new_entry.flags = {r_msb, (alu_result == '0), alu_cout, ovf};
    rd_next         = rd_ptr + PTR_W'(pop);
    count_after_pop = count - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push);
    // Head slot is only unwritten in memory when the queue drains to the new entry.
    next_head = (push && (count_after_pop == '0)) ? new_entry : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_tag   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head    <= '0;
      flags   <= '0;
    end else begin
      p_valid <= accept;
      if (accept) p_tag <= {issue_dst, issue_sub, issue_a_msb, issue_b_msb};
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      // Holding when empty keeps the last written address/data on the outputs.
      if (count_next != '0) head <= next_head;
      if (pop) flags <= head.flags;
    end
  end

endmodule
